// File: rtl/uart_tx_engine.sv
// uart_tx_engine: drains the TX FIFO and serialises each byte as an 8N1/8N2 frame, LSB first.
// Define UART_TX_PARITY_EN to insert an even parity bit after the data bits (8E1/8E2).
module uart_tx_engine #(
    parameter int CLK_DIV   = 104,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_pop,
    output logic       tx,
    output logic       busy
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0] bit_idx, bit_d;
    logic [7:0] shift, shift_d;
    logic tx_d, busy_d, pop_d, tick;
`ifdef UART_TX_PARITY_EN
    logic par, par_d;
`endif

    assign tick = (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            fifo_pop <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bit_idx  <= bit_d;
            shift    <= shift_d;
            tx       <= tx_d;
            busy     <= busy_d;
            fifo_pop <= pop_d;
`ifdef UART_TX_PARITY_EN
            par      <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bit_d   = bit_idx;
        shift_d = shift;
        tx_d    = tx;
        busy_d  = busy;
        pop_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par;
`endif
        case (state)
            IDLE: if (enable && !fifo_empty) begin
                pop_d   = 1'b1;
                busy_d  = 1'b1;
                state_d = POP;
            end
            POP: state_d = LOAD;
            LOAD: begin
                shift_d = fifo_data;
                tx_d    = 1'b0;
                cnt_d   = '0;
                bit_d   = '0;
                state_d = START;
`ifdef UART_TX_PARITY_EN
                par_d   = ^fifo_data;
`endif
            end
            START: begin
                cnt_d = tick ? '0 : cnt + CW'(1);
                if (tick) begin
                    tx_d    = shift[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = tick ? '0 : cnt + CW'(1);
                if (tick) begin
                    shift_d = shift >> 1;
                    bit_d   = bit_idx + 3'd1;
                    tx_d    = shift[1];
                    if (bit_idx == 3'd7) begin
                        bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                        tx_d    = par;
                        state_d = PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                cnt_d = tick ? '0 : cnt + CW'(1);
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                cnt_d = tick ? '0 : cnt + CW'(1);
                if (tick) begin
                    bit_d = bit_idx + 3'd1;
                    if (bit_idx == LAST_STOP) begin
                        // chain straight into the next frame while data is queued
                        bit_d = '0;
                        if (enable && !fifo_empty) begin
                            pop_d   = 1'b1;
                            state_d = POP;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed checks of uart_tx_engine at CLK_DIV=4 (STOP_BITS 1 and 2).
// Expected tx/busy/fifo_pop traces are built per clk cycle from the byte values.
module tb_uart_tx_engine;
    localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
    logic [7:0] fifo_data = 8'h00;
    logic fifo_empty, fifo_pop, tx, busy;
    logic empty2 = 1'b1, pop2, tx2, busy2;
    logic [7:0] mem [16];
    int wr = 0, rd = 0, checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (wr == rd);
    always @(posedge clk) if (fifo_pop) begin
        fifo_data <= mem[rd[3:0]];
        rd <= rd + 1;
    end

    uart_tx_engine #(.CLK_DIV(DIV), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_pop(fifo_pop), .tx(tx), .busy(busy)
    );

    uart_tx_engine #(.CLK_DIV(DIV), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_data(8'h03),
        .fifo_empty(empty2), .fifo_pop(pop2), .tx(tx2), .busy(busy2)
    );

    function automatic int flen(input int ns);
        return 2 + DIV * (10 + ns - 1 + PB);
    endfunction

    // trace from the pop cycle: POP and LOAD cycles high, then start, data, parity, stop
    function automatic logic [63:0] frame(input logic [7:0] d);
        logic [63:0] f = '1;
        logic [15:0] per = '1;
        per[0] = 1'b0;
        per[8:1] = d;
        per[9] = (PB == 1) ? ^d : 1'b1;
        for (int i = 0; i < 9 + PB; i++)
            for (int j = 0; j < DIV; j++) f[2 + i * DIV + j] = per[i];
        return f;
    endfunction

    function automatic void add_frame(inout logic [255:0] et, inout logic [255:0] eb,
                                      inout logic [255:0] ep, input int off,
                                      input logic [7:0] d, input int ns);
        logic [63:0] f = frame(d);
        for (int i = 0; i < flen(ns); i++) begin
            et[off + i] = f[i];
            eb[off + i] = 1'b1;
            ep[off + i] = (i == 0);
        end
    endfunction

    task automatic push(input logic [7:0] b);
        mem[wr[3:0]] = b;
        wr++;
    endtask

    task automatic wait_pop(input int sel);
        int k = 0;
        while (!(sel != 0 ? pop2 : fifo_pop) && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 50) begin
            errors++;
            $display("FAIL wait_pop%0d: no fifo_pop within 50 clk, required one", sel);
        end
    endtask

    task automatic capture(input int n, input int sel, input int drop_at,
                           output logic [255:0] t, output logic [255:0] b,
                           output logic [255:0] p);
        t = '1; b = '0; p = '0;
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) enable = 1'b0;
            t[i] = sel != 0 ? tx2 : tx;
            b[i] = sel != 0 ? busy2 : busy;
            p[i] = sel != 0 ? pop2 : fifo_pop;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int pops = 0, lows = 0, busys = 0;
        reset = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        checks += 3;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b want 0", fifo_pop); end
        reset = 1'b0;
        repeat (100) begin
            @(negedge clk);
            pops += int'(fifo_pop) + int'(pop2);
            lows += int'(!tx) + int'(!tx2);
            busys += int'(busy) + int'(busy2);
        end
        checks += 3;
        if (pops != 0) begin errors++; $display("FAIL idle_pops: got %0d want 0", pops); end
        if (lows != 0) begin errors++; $display("FAIL idle_tx_low: got %0d cycles want 0", lows); end
        if (busys != 0) begin errors++; $display("FAIL idle_busy: got %0d cycles want 0", busys); end
    endtask

    task automatic test_single;
        logic [255:0] t, b, p, et, eb, ep;
        int n = flen(1) + 2;
        et = '1; eb = '0; ep = '0;
        push(8'h55);
        wait_pop(0);
        capture(n, 0, -1, t, b, p);
        add_frame(et, eb, ep, 0, 8'h55, 1);
        checks += 3;
        if (t !== et) begin errors++; $display("FAIL single_tx: got %h want %h", t, et); end
        if (b !== eb) begin errors++; $display("FAIL single_busy: got %h want %h", b, eb); end
        if (p !== ep) begin errors++; $display("FAIL single_pop: got %h want %h", p, ep); end
    endtask

    task automatic test_back_to_back(input logic [7:0] a, input logic [7:0] c);
        logic [255:0] t, b, p, et, eb, ep;
        int l = flen(1);
        et = '1; eb = '0; ep = '0;
        push(a);
        push(c);
        wait_pop(0);
        capture(2 * l + 2, 0, -1, t, b, p);
        add_frame(et, eb, ep, 0, a, 1);
        add_frame(et, eb, ep, l, c, 1);
        checks += 3;
        if (t !== et) begin errors++; $display("FAIL b2b_tx %h/%h: got %h want %h", a, c, t, et); end
        if (b !== eb) begin errors++; $display("FAIL b2b_busy %h/%h: got %h want %h", a, c, b, eb); end
        if (p !== ep) begin errors++; $display("FAIL b2b_pop %h/%h: got %h want %h", a, c, p, ep); end
    endtask

    task automatic test_reset_mid;
        int pops = 0, lows = 0, busys = 0;
        push(8'hFF);
        wait_pop(0);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        checks += 3;
        if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b want 1", tx); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
        if (fifo_pop !== 1'b0) begin errors++; $display("FAIL midreset_pop: got %b want 0", fifo_pop); end
        @(negedge clk);
        reset = 1'b0;
        repeat (30) begin
            @(negedge clk);
            pops += int'(fifo_pop);
            lows += int'(!tx);
            busys += int'(busy);
        end
        checks += 3;
        if (pops != 0) begin errors++; $display("FAIL postreset_pops: got %0d want 0", pops); end
        if (lows != 0) begin errors++; $display("FAIL postreset_tx_low: got %0d want 0", lows); end
        if (busys != 0) begin errors++; $display("FAIL postreset_busy: got %0d want 0", busys); end
    endtask

    task automatic test_enable_drop;
        logic [255:0] t, b, p, et, eb, ep;
        int l = flen(1);
        et = '1; eb = '0; ep = '0;
        push(8'h11);
        push(8'h22);
        wait_pop(0);
        capture(l + 30, 0, 10, t, b, p);
        add_frame(et, eb, ep, 0, 8'h11, 1);
        checks += 3;
        if (t !== et) begin errors++; $display("FAIL drop_tx: got %h want %h", t, et); end
        if (b !== eb) begin errors++; $display("FAIL drop_busy: got %h want %h", b, eb); end
        if (p !== ep) begin errors++; $display("FAIL drop_pop: got %h want %h", p, ep); end
        enable = 1'b1;
        et = '1; eb = '0; ep = '0;
        wait_pop(0);
        capture(l + 2, 0, -1, t, b, p);
        add_frame(et, eb, ep, 0, 8'h22, 1);
        checks += 3;
        if (t !== et) begin errors++; $display("FAIL resume_tx: got %h want %h", t, et); end
        if (b !== eb) begin errors++; $display("FAIL resume_busy: got %h want %h", b, eb); end
        if (p !== ep) begin errors++; $display("FAIL resume_pop: got %h want %h", p, ep); end
    endtask

    task automatic test_two_stop;
        logic [255:0] t, b, p, et, eb, ep;
        et = '1; eb = '0; ep = '0;
        empty2 = 1'b0;
        wait_pop(1);
        empty2 = 1'b1;
        capture(flen(2) + 2, 1, -1, t, b, p);
        add_frame(et, eb, ep, 0, 8'h03, 2);
        checks += 3;
        if (t !== et) begin errors++; $display("FAIL stop2_tx: got %h want %h", t, et); end
        if (b !== eb) begin errors++; $display("FAIL stop2_busy: got %h want %h", b, eb); end
        if (p !== ep) begin errors++; $display("FAIL stop2_pop: got %h want %h", p, ep); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back(8'hA3, 8'h0F);
        test_reset_mid;
        test_enable_drop;
        test_back_to_back(8'h07, 8'h03);
        test_two_stop;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
